data_mem_unit: RTL and testbench

//  Data-memory responder for the load/store path. It consumes mem_read, mem_write and funct3

---
 rtl/data_mem_unit.sv | 167 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-memory responder for the load/store path: byte/half/word accesses to a word RAM
// with a programmable wait latency, stalling the core until each access completes.
module data_mem_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_store;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_mis;

  logic                  w_req, w_accept, w_commit, w_we;
  logic                  w_store;
  logic [2:0]            w_f3;
  logic [ADDR_WIDTH+1:0] w_addr;
  logic [31:0]           w_wdata, w_wdata_rep, w_load_val;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic [3:0][7:0]       w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_is_half, w_is_word, w_mis;
  logic                  w_unused;

  assign w_unused = &{1'b0, addr[31:ADDR_WIDTH+2]};

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == IDLE) && w_req;

  // With zero wait cycles the access commits on the accept edge, so use the live inputs.
  assign w_store = (r_state == IDLE) ? mem_write : r_store;
  assign w_f3    = (r_state == IDLE) ? funct3 : r_f3;
  assign w_addr  = (r_state == IDLE) ? addr[ADDR_WIDTH+1:0] : r_addr;
  assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;

  assign w_idx     = w_addr[ADDR_WIDTH+1:2];
  assign w_is_half = (w_f3[1:0] == 2'b01);
  assign w_is_word = w_f3[1];
  assign w_mis     = (w_is_half && w_addr[0]) || (w_is_word && (w_addr[1:0] != 2'b00));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_next = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            w_state_next = DONE;
            w_commit     = 1'b1;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = w_wdata;
    if (w_f3[1:0] == 2'b00) begin
      w_be        = 4'b0001 << w_addr[1:0];
      w_wdata_rep = {4{w_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata_rep = {2{w_wdata[15:0]}};
    end
  end

  // A reset on the commit edge must suppress the write.
  assign w_we = w_commit && w_store && !w_mis && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];
      always_ff @(posedge clk) begin
        if (w_we && w_be[gi]) begin
          r_lane[w_idx] <= w_wdata_rep[gi*8 +: 8];
        end
      end
      assign w_word[gi] = r_lane[w_idx];
    end
  endgenerate

  assign w_byte = w_word[w_addr[1:0]];
  assign w_half = w_addr[1] ? {w_word[3], w_word[2]} : {w_word[1], w_word[0]};

  always_comb begin
    w_load_val = w_word;
    case (w_f3[1:0])
      2'b00:   w_load_val = w_f3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_val = w_f3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_val = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_store <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_store <= mem_write;
        r_f3    <= funct3;
        r_addr  <= addr[ADDR_WIDTH+1:0];
        r_wdata <= wdata;
      end
      if (w_commit) begin
        r_mis <= w_mis;
        if (w_mis) begin
          r_rdata <= 32'd0;
        end else if (!w_store) begin
          r_rdata <= w_load_val;
        end
      end
    end
  end

  assign rdata      = r_rdata;
  assign stall      = w_accept || (r_state == BUSY);
  assign done       = (r_state == DONE);
  assign misaligned = (r_state == DONE) && r_mis;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a WAIT_CYCLES=2 instance for the access tests and a
// WAIT_CYCLES=0 instance for back-to-back streaming and address aliasing.
module tb_data_mem_unit;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    bit          chk_rd;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, misaligned;
  logic        rst0, mem_read0, mem_write0;
  logic [2:0]  funct30;
  logic [31:0] addr0, wdata0, rdata0;
  logic        stall0, done0, misaligned0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  data_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .misaligned(misaligned)
  );

  data_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .mem_read(mem_read0), .mem_write(mem_write0), .funct3(funct30),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .stall(stall0), .done(done0),
    .misaligned(misaligned0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done_a actual=done required=no_done");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        if (e.chk_rd) chk({e.name, "_rdata"}, rdata, e.rd);
        chk({e.name, "_mis"}, {31'd0, misaligned}, {31'd0, e.mis});
        $display("A %s rdata=%h mis=%b", e.name, rdata, misaligned);
      end
    end
  end

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done_b actual=done required=no_done");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        if (e.chk_rd) chk({e.name, "_rdata"}, rdata0, e.rd);
        chk({e.name, "_mis"}, {31'd0, misaligned0}, {31'd0, e.mis});
        $display("B %s rdata=%h mis=%b", e.name, rdata0, misaligned0);
      end
    end
  end

  task automatic set_in(input int which, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    if (which == 0) begin
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    end else begin
      mem_read0 = rd; mem_write0 = wr; funct30 = f3; addr0 = a; wdata0 = wd;
    end
  endtask

  // Stores also raise mem_read, as the control stage does.
  task automatic access(input int which, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis,
                        input bit chk_rd, input string name);
    exp_t e;
    int   stalls = 0;
    bit   got    = 0;
    int   waitc  = (which == 0) ? 2 : 0;
    e.rd = exp_rd; e.mis = exp_mis; e.chk_rd = chk_rd; e.name = name;
    if (which == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge clk); #1;
    set_in(which, 1'b1, st, f3, a, wd);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (((which == 0) ? stall : stall0) === 1'b1) stalls++;
      if (((which == 0) ? done : done0) === 1'b1) got = 1;
    end
    set_in(which, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      chk({name, "_stall_cycles"}, stalls, waitc + 1);
    end
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    set_in(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_in(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst0 = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_mis", {31'd0, misaligned}, 32'd0);
    chk("reset0_rdata", rdata0, 32'd0);

    // Word, byte and half accesses on the WAIT_CYCLES=2 instance.
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 1, "sw_10");
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, "lw_10");
    access(0, 1, 3'b000, 32'h11, 32'h12345680, 32'hDEADBEEF, 0, 1, "sb_11");
    access(0, 0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 0, 1, "lb_11");
    access(0, 0, 3'b100, 32'h11, 32'h0,        32'h00000080, 0, 1, "lbu_11");
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 0, 1, "lw_10_b");
    access(0, 1, 3'b001, 32'h12, 32'hABCD1234, 32'hDEAD80EF, 0, 1, "sh_12");
    access(0, 0, 3'b001, 32'h12, 32'h0,        32'h00001234, 0, 1, "lh_12");
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 0, 1, "lw_10_h");
    access(0, 0, 3'b001, 32'h10, 32'h0,        32'hFFFF80EF, 0, 1, "lh_10");
    access(0, 0, 3'b101, 32'h10, 32'h0,        32'h000080EF, 0, 1, "lhu_10");
    access(0, 0, 3'b011, 32'h10, 32'h0,        32'h123480EF, 0, 1, "f3_011_10");
    // Misaligned accesses.
    access(0, 0, 3'b010, 32'h13, 32'h0,        32'h00000000, 1, 1, "lw_13_mis");
    access(0, 1, 3'b010, 32'h13, 32'hFFFFFFFF, 32'h00000000, 1, 0, "sw_13_mis");
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 0, 1, "lw_10_after_mis");
    access(0, 0, 3'b001, 32'h11, 32'h0,        32'h00000000, 1, 1, "lh_11_mis");
    access(0, 0, 3'b100, 32'h13, 32'h0,        32'h00000012, 0, 1, "lbu_13");
    access(0, 0, 3'b010, 32'h410, 32'h0,       32'h123480EF, 0, 1, "lw_410_wrap");
    access(0, 1, 3'b010, 32'h20, 32'h11223344, 32'h123480EF, 0, 1, "sw_20");

    // Reset in the middle of a store: no write, no done.
    @(posedge clk); #1;
    set_in(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h00000055);
    @(negedge clk);
    chk("abort_stall_idle", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("abort_stall_busy", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    repeat (5) @(negedge clk);
    access(0, 0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, 1, "lw_20_after_abort");

    // WAIT_CYCLES=0: store held high streams one access every two cycles.
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.rd = 32'd0; e.mis = 1'b0; e.chk_rd = 1'b1; e.name = $sformatf("stream_sw_%0d", k);
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    set_in(1, 1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stream_stall_%0d", i), {31'd0, stall0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("stream_done_%0d", i), {31'd0, done0}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    set_in(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    access(1, 0, 3'b010, 32'h000, 32'h0, 32'hCAFEF00D, 0, 1, "lw0_000_alias");
    access(1, 0, 3'b000, 32'h403, 32'h0, 32'hFFFFFFCA, 0, 1, "lb0_403");
    access(1, 0, 3'b001, 32'h401, 32'h0, 32'h00000000, 1, 1, "lh0_401_mis");

    repeat (4) @(negedge clk);
    chk("queue_a_empty", q_a.size(), 32'd0);
    chk("queue_b_empty", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
